// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator/checker pair: FSM encodings and the
// substitute tap used when the supplied mask is degenerate.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // All-zeros and all-ones masks are replaced by x^1 so the register never sticks.
  localparam int DEGEN_TAP = 2;

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR step with tap sanitising; used by both generator and checker
// so the two cannot drift apart.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] tap_i,
  input  logic [SIZE-1:0] p_i,
  output logic [SIZE-1:0] next_o
);

  localparam logic [SIZE-1:0] DEGEN_W = SIZE'(DEGEN_TAP);

  logic            degen;
  logic [SIZE-1:1] eff;
  logic            fb;

  assign degen = (tap_i == '0) || (tap_i == '1);
  assign eff   = degen ? DEGEN_W[SIZE-1:1] : tap_i[SIZE-1:1];
  // Folding in the zero-detect makes the all-zeros word part of the cycle.
  assign fb    = p_i[SIZE-1] ^ (p_i[SIZE-2:0] == '0);

  assign next_o[0] = fb;

  for (genvar b = 1; b < SIZE; b++) begin : g_bit
    assign next_o[b] = eff[b] ? (p_i[b-1] ^ fb) : p_i[b-1];
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: acquires lock on a clean run of words, then
// flywheels its own reference and counts mismatches while locked.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIZE-1:0]  tap,
  input  logic             in_valid,
  input  logic [SIZE-1:0]  in_data,
  input  logic             resync,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);
  localparam logic [SW-1:0] LOSS_N = SW'(LOSS_COUNT);

  state_e           state_q, state_d;
  logic [SIZE-1:0]  ref_q, ref_d;
  logic [MW-1:0]    match_q, match_d;
  logic [SW-1:0]    miss_q, miss_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             locked_q;
  logic [SIZE-1:0]  exp_w;
  logic             hit;

  lfsr_step #(.SIZE(SIZE)) u_step (
    .tap_i  (tap),
    .p_i    (ref_q),
    .next_o (exp_w)
  );

  assign hit = (in_data == exp_w);

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    match_d = match_q;
    miss_d  = miss_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (resync) begin
      state_d = ST_IDLE;
      match_d = '0;
      miss_d  = '0;
    end else if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          ref_d   = in_data;
          match_d = '0;
          state_d = ST_SEARCH;
        end
        ST_SEARCH: begin
          ref_d = in_data;
          if (hit) begin
            match_d = match_q + 1'b1;
            if (match_d == LOCK_N) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: a corrupted word must not poison the reference.
          ref_d = exp_w;
          if (!hit) begin
            err_d  = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            miss_d = miss_q + 1'b1;
            if (miss_d == LOSS_N) begin
              state_d = ST_SEARCH;
              ref_d   = in_data;
              match_d = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ref_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      locked_q <= (state_d == ST_LOCKED);
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule
